dispatch_ctrl: RTL

Dispatch scheduler between the instruction queue and the decode stage. It decides each cycle whether the head queue packet may enter decode, using credit counters for ROB, reservation-station and load/store-queue capacity. It allocates the ROB tail ID that decode forwards as rob_id_dest. It serializes CSR instructions behind an empty ROB and recovers on branch mispredict.

---
 rtl/dispatch_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: decides each cycle whether the head instruction-queue packet
// enters decode. ROB, RS and LSQ credit counters bound the number of in-flight
// instructions. The block hands out ROB tail IDs, holds CSR instructions until
// the ROB has drained, and restores full credit after a branch mispredict.
module dispatch_ctrl #(
  parameter int ROB_DEPTH   = 16,
  parameter int RS_DEPTH    = 8,
  parameter int LSQ_DEPTH   = 8,
  parameter int ROB_ID_SIZE = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         branch_mispredict,
  input  logic                         queue_empty,
  input  logic [63:0]                  queue_packet,
  output logic                         queue_dequeue,
  output logic                         valid_inst,
  output logic [ROB_ID_SIZE-1:0]       rob_id_dest,
  input  logic                         rob_commit,
  input  logic                         rs_release,
  input  logic                         lsq_release,
  output logic [ROB_ID_SIZE:0]         rob_credit,
  output logic [$clog2(RS_DEPTH):0]    rs_credit,
  output logic [$clog2(LSQ_DEPTH):0]   lsq_credit,
  output logic                         stall,
  output logic                         credit_err
);

  localparam int ROB_CW = ROB_ID_SIZE + 1;
  localparam int RS_CW  = $clog2(RS_DEPTH) + 1;
  localparam int LSQ_CW = $clog2(LSQ_DEPTH) + 1;

  localparam logic [ROB_CW-1:0] ROB_FULL = ROB_DEPTH[ROB_CW-1:0];
  localparam logic [RS_CW-1:0]  RS_FULL  = RS_DEPTH[RS_CW-1:0];
  localparam logic [LSQ_CW-1:0] LSQ_FULL = LSQ_DEPTH[LSQ_CW-1:0];

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SER   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  logic [1:0]             state_q, state_d;
  logic [ROB_CW-1:0]      rob_credit_q, rob_credit_d;
  logic [RS_CW-1:0]       rs_credit_q, rs_credit_d;
  logic [LSQ_CW-1:0]      lsq_credit_q, lsq_credit_d;
  logic [ROB_ID_SIZE-1:0] rob_id_q, rob_id_d;
  logic                   credit_err_q, credit_err_d;

  logic [6:0] opcode;
  logic       is_mem;
  logic       is_csr;
  logic       dispatch_ok;
  logic       dispatch;
  logic       rob_consume, rs_consume, lsq_consume;
  logic       rob_ovf, rs_ovf, lsq_ovf;

  // Only the opcode field of the packet matters here; the PC and the rest of
  // the instruction word pass straight through to decode.
  logic unused_pkt_bits;
  assign unused_pkt_bits = ^queue_packet[63:7];

  // Classify the head packet and check whether every credit it needs is free.
  always_comb begin
    opcode      = queue_packet[6:0];
    is_mem      = (opcode == OP_LOAD) || (opcode == OP_STORE);
    is_csr      = (opcode == OP_CSR);
    dispatch_ok = !queue_empty && (rob_credit_q != '0) &&
                  (is_mem ? (lsq_credit_q != '0) : (rs_credit_q != '0));
  end

  // Dispatch FSM: a CSR waits in SER until the ROB is empty; a mispredict
  // kills dispatch in its own cycle and then costs one FLUSH bubble.
  always_comb begin
    state_d  = state_q;
    dispatch = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!queue_empty && is_csr && (rob_credit_q != ROB_FULL)) begin
          state_d = ST_SER;
        end else begin
          dispatch = dispatch_ok;
        end
      end
      ST_SER: begin
        if (rob_credit_q == ROB_FULL) begin
          dispatch = dispatch_ok;
          state_d  = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (branch_mispredict) begin
      dispatch = 1'b0;
      state_d  = ST_FLUSH;
    end
  end

  // Split the dispatch into the credits it consumes; CSR counts as non-mem.
  always_comb begin
    rob_consume = dispatch;
    rs_consume  = dispatch && !is_mem;
    lsq_consume = dispatch && is_mem;
  end

  // ROB credit: consume on dispatch, return on commit, saturate at full.
  always_comb begin
    rob_credit_d = rob_credit_q;
    rob_ovf      = 1'b0;
    if (branch_mispredict) begin
      rob_credit_d = ROB_FULL;
    end else if (rob_commit && !rob_consume && (rob_credit_q == ROB_FULL)) begin
      rob_ovf = 1'b1;
    end else begin
      rob_credit_d = rob_credit_q - {{(ROB_CW-1){1'b0}}, rob_consume}
                                  + {{(ROB_CW-1){1'b0}}, rob_commit};
    end
  end

  // RS credit: consume on non-mem dispatch, return on issue, saturate at full.
  always_comb begin
    rs_credit_d = rs_credit_q;
    rs_ovf      = 1'b0;
    if (branch_mispredict) begin
      rs_credit_d = RS_FULL;
    end else if (rs_release && !rs_consume && (rs_credit_q == RS_FULL)) begin
      rs_ovf = 1'b1;
    end else begin
      rs_credit_d = rs_credit_q - {{(RS_CW-1){1'b0}}, rs_consume}
                                + {{(RS_CW-1){1'b0}}, rs_release};
    end
  end

  // LSQ credit: consume on load/store dispatch, return on release, saturate.
  always_comb begin
    lsq_credit_d = lsq_credit_q;
    lsq_ovf      = 1'b0;
    if (branch_mispredict) begin
      lsq_credit_d = LSQ_FULL;
    end else if (lsq_release && !lsq_consume && (lsq_credit_q == LSQ_FULL)) begin
      lsq_ovf = 1'b1;
    end else begin
      lsq_credit_d = lsq_credit_q - {{(LSQ_CW-1){1'b0}}, lsq_consume}
                                  + {{(LSQ_CW-1){1'b0}}, lsq_release};
    end
  end

  // Tail ID advances per dispatch and wraps naturally at 2**ROB_ID_SIZE;
  // the error flag accumulates any over-release and is cleared only by reset.
  always_comb begin
    rob_id_d = rob_id_q + {{(ROB_ID_SIZE-1){1'b0}}, dispatch};
    if (branch_mispredict) begin
      rob_id_d = '0;
    end
    credit_err_d = credit_err_q | rob_ovf | rs_ovf | lsq_ovf;
  end

  // State registers with synchronous reset; reset overrides a mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      rob_credit_q <= ROB_FULL;
      rs_credit_q  <= RS_FULL;
      lsq_credit_q <= LSQ_FULL;
      rob_id_q     <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rob_credit_q <= rob_credit_d;
      rs_credit_q  <= rs_credit_d;
      lsq_credit_q <= lsq_credit_d;
      rob_id_q     <= rob_id_d;
      credit_err_q <= credit_err_d;
    end
  end

  // Dispatch is zero-latency; stall is suppressed during the FLUSH bubble.
  always_comb begin
    queue_dequeue = dispatch;
    valid_inst    = dispatch;
    stall         = !queue_empty && !dispatch && (state_q != ST_FLUSH);
    rob_id_dest   = rob_id_q;
    rob_credit    = rob_credit_q;
    rs_credit     = rs_credit_q;
    lsq_credit    = lsq_credit_q;
    credit_err    = credit_err_q;
  end

endmodule
